mem_word_reader: RTL and testbench
==================================

Name: mem_word_reader

Overview:
- Read-side controller that fetches one 16-bit word from the byte-wide (8-bit) synchronous data/instruction memory for the multi-cycle CPU.
- Takes a request and byte address from the CPU control FSM, issues two byte reads, and assembles the word according to ENDIAN.
- Returns the word with a one-cycle valid pulse.
- Sits between the CPU control unit (IF/MEM stages) and the 8-bit memory array.

Parameters:
- ADDR_W, 16: byte-address width.
- ENDIAN, 0: 0 = little-endian (byte[A] is the low byte); 1 = big-endian (byte[A] is the high byte).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- req  input  1  read request; sampled only in IDLE.
- addr  input  ADDR_W  byte address of the word; sampled with req.
- busy  output  1  high while a read is in progress (state != IDLE).
- rdata  output  16  assembled word; holds its value until the next completion.
- valid  output  1  one-cycle pulse when rdata is updated.
- mem_re  output  1  memory read enable (registered).
- mem_addr  output  ADDR_W  memory byte address (registered).
- mem_rdata  input  8  memory read data; valid on the edge after the memory samples mem_re/mem_addr (1-cycle read latency).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, valid=0, rdata=16'h0000, mem_re=0, mem_addr=0.
  - Internal low-byte holding register cleared.
- FSM states: IDLE, RD_LO, RD_HI, CAP_HI. busy = (state != IDLE), decoded combinationally from the state register.
- Edge E0, IDLE with req=1:
  - Latch addr as A.
  - Set mem_re=1, mem_addr=A; go to RD_LO.
- Edge E1, RD_LO (memory samples A):
  - Set mem_addr=A+1 (mod 2^ADDR_W), mem_re=1; go to RD_HI.
- Edge E2, RD_HI:
  - Capture mem_rdata (byte[A]) into the holding register.
  - Set mem_re=0; go to CAP_HI.
- Edge E3, CAP_HI:
  - ENDIAN=0: rdata <= {mem_rdata, held}. ENDIAN=1: rdata <= {held, mem_rdata}.
  - valid <= 1; go to IDLE.
- Edge E4: valid <= 0.
- Latency and throughput:
  - Request to valid: valid is high in the cycle following E3, i.e. 3 edges after acceptance.
  - Throughput is one word per 4 cycles. The next request is accepted at E4 at the earliest; valid=1 and req=1 may coexist in that cycle.
- req while busy=1: ignored; not queued, no error. addr changes while busy have no effect.
- Address wrap: A=max (all ones) reads the second byte from address 0.
- Unaligned addresses (A odd) are legal; no alignment check.
- valid is never high for two consecutive cycles.
- rdata changes only at completion edges (E3).
- Asynchronous reset mid-operation:
  - Aborts the read and returns all outputs to reset values in the same instant.
  - No valid is generated for the aborted read.
  - After rst is released, the first request behaves normally.
- mem_re is high for exactly two consecutive cycles per read: address A, then A+1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=1 -> busy=0, valid=0, rdata=0000, mem_re=0 throughout; release rst, no activity until req is sampled in IDLE.
- Single read, ENDIAN=0: memory byte[0x0010]=0x34, byte[0x0011]=0x12, req pulse with addr=0x0010 -> mem_addr sequence 0x0010 then 0x0011 with mem_re=1; rdata=0x1234 and valid=1 for exactly one cycle after E3; rdata holds 0x1234 afterwards.
- Big-endian instance (ENDIAN=1), same memory contents -> rdata=0x3412.
- Wrap and unaligned: byte[0xFFFF]=0xCD, byte[0x0000]=0xAB, addr=0xFFFF -> second mem_addr=0x0000, rdata=0xABCD.
- Back-to-back: req held high continuously with addr=0x0020 then 0x0022 -> first valid 3 edges after acceptance, second request accepted at E4, valid pulses exactly 4 cycles apart; addr changes while busy are ignored.
- Reset mid-read: assert rst=0 while the FSM is in RD_HI -> mem_re=0, busy=0, valid never pulses and rdata remains at its reset value; after release, a fresh read of 0x0010 returns 0x1234.

Source files
------------

// File: rtl/mem_word_reader.sv
// rtl/mem_word_reader.sv - fetches one 16-bit word as two byte reads from 8-bit synchronous memory
module mem_word_reader #(
    parameter int ADDR_W = 16,
    parameter bit ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [15:0]       rdata,
    output logic              valid,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_LO  = 2'd1,
        RD_HI  = 2'd2,
        CAP_HI = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        held;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = RD_LO;
            RD_LO:   state_next = RD_HI;
            RD_HI:   state_next = CAP_HI;
            CAP_HI:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Memory data lags its address by one edge, so byte[A] is captured in RD_HI
    // and byte[A+1] in CAP_HI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            held     <= 8'h00;
            rdata    <= 16'h0000;
            valid    <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= addr;
                        mem_re   <= 1'b1;
                        mem_addr <= addr;
                    end
                end
                RD_LO: begin
                    mem_re   <= 1'b1;
                    mem_addr <= addr_q + ADDR_W'(1);
                end
                RD_HI: begin
                    held   <= mem_rdata;
                    mem_re <= 1'b0;
                end
                CAP_HI: begin
                    rdata <= ENDIAN ? {held, mem_rdata} : {mem_rdata, held};
                    valid <= 1'b1;
                end
                default: begin
                    mem_re <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_reader.sv
// tb/tb_mem_word_reader.sv - directed bench for little- and big-endian mem_word_reader instances
module tb_mem_word_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [15:0] addr = 16'h0000;

    logic        busy_le, valid_le, mem_re_le;
    logic [15:0] rdata_le, mem_addr_le;
    logic [7:0]  mem_rdata_le = 8'h00;
    logic        busy_be, valid_be, mem_re_be;
    logic [15:0] rdata_be, mem_addr_be;
    logic [7:0]  mem_rdata_be = 8'h00;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_word_reader #(.ADDR_W(16), .ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .busy(busy_le),
        .rdata(rdata_le), .valid(valid_le), .mem_re(mem_re_le),
        .mem_addr(mem_addr_le), .mem_rdata(mem_rdata_le)
    );

    mem_word_reader #(.ADDR_W(16), .ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .busy(busy_be),
        .rdata(rdata_be), .valid(valid_be), .mem_re(mem_re_be),
        .mem_addr(mem_addr_be), .mem_rdata(mem_rdata_be)
    );

    always @(posedge clk) begin
        if (mem_re_le) mem_rdata_le <= mem[mem_addr_le];
        if (mem_re_be) mem_rdata_be <= mem[mem_addr_be];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_le;
        logic [15:0] exp_be;
    } vec_t;

    vec_t vecs [5];

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp_le, input logic [15:0] exp_be);
        logic [15:0] a1;
        a1 = a + 16'd1;
        @(negedge clk);
        req  = 1'b1;
        addr = a;
        @(negedge clk);
        req  = 1'b0;
        addr = ~a;
        chk("e0_busy", busy_le, 1);
        chk("e0_mem_re", mem_re_le, 1);
        chk("e0_mem_addr", mem_addr_le, a);
        @(negedge clk);
        chk("e1_mem_re", mem_re_le, 1);
        chk("e1_mem_addr", mem_addr_le, a1);
        @(negedge clk);
        chk("e2_mem_re", mem_re_le, 0);
        chk("e2_valid", valid_le, 0);
        @(negedge clk);
        chk("e3_valid_le", valid_le, 1);
        chk("e3_valid_be", valid_be, 1);
        chk("e3_rdata_le", rdata_le, exp_le);
        chk("e3_rdata_be", rdata_be, exp_be);
        @(negedge clk);
        chk("e4_valid", valid_le, 0);
        chk("e4_busy", busy_le, 0);
        chk("e4_rdata_hold", rdata_le, exp_le);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h0010, 8'h34, 8'h12, 16'h1234, 16'h3412};
        vecs[1] = '{16'hFFFF, 8'hCD, 8'hAB, 16'hABCD, 16'hCDAB};
        vecs[2] = '{16'h0021, 8'h5A, 8'hA5, 16'hA55A, 16'h5AA5};
        vecs[3] = '{16'h0000, 8'h00, 8'hFF, 16'hFF00, 16'h00FF};
        vecs[4] = '{16'h8000, 8'h01, 8'h80, 16'h8001, 16'h0180};

        // reset held with req asserted
        rst = 1'b0;
        req = 1'b1;
        addr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy_le, 0);
            chk("rst_valid", valid_le, 0);
            chk("rst_rdata", rdata_le, 16'h0000);
            chk("rst_mem_re", mem_re_le, 0);
        end
        req = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy_le, 0);
        chk("idle_mem_re", mem_re_le, 0);
        chk("idle_mem_addr", mem_addr_le, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            mem[vecs[i].a] = vecs[i].b0;
            mem[vecs[i].a + 16'd1] = vecs[i].b1;
            do_read(vecs[i].a, vecs[i].exp_le, vecs[i].exp_be);
        end

        // back-to-back with req held high; addr change while busy must be ignored
        mem[16'h0020] = 8'h11;
        mem[16'h0021] = 8'h22;
        mem[16'h0022] = 8'h33;
        mem[16'h0023] = 8'h44;
        @(negedge clk);
        req  = 1'b1;
        addr = 16'h0020;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk("b2b_valid", valid_le, (k == 3 || k == 7) ? 1 : 0);
            if (k == 3) chk("b2b_rdata1", rdata_le, 16'h2211);
            if (k == 4) begin
                chk("b2b_accept_busy", busy_le, 1);
                chk("b2b_accept_addr", mem_addr_le, 16'h0022);
            end
            if (k == 7) begin
                chk("b2b_rdata2_le", rdata_le, 16'h4433);
                chk("b2b_rdata2_be", rdata_be, 16'h3344);
            end
            if (k == 0) addr = 16'h0022;
            if (k == 4) req = 1'b0;
        end

        // asynchronous reset while in RD_HI
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        @(negedge clk);
        req  = 1'b1;
        addr = 16'h0010;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy_le, 0);
        chk("arst_mem_re", mem_re_le, 0);
        chk("arst_mem_addr", mem_addr_le, 16'h0000);
        chk("arst_rdata", rdata_le, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_valid", valid_le, 0);
            chk("arst_rdata_hold", rdata_le, 16'h0000);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", valid_le, 0);
        do_read(16'h0010, 16'h1234, 16'h3412);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
